// File: rtl/jtcps1_gfx_resp_if.sv
// Scroll GFX fetch port (ROM side) and SDRAM slot port of jtcps1_gfx_resp.
// The responder uses the slave view; the requester/arbiter side uses master.
interface jtcps1_gfx_resp_if;
    localparam int unsigned AW = 20;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 22;

    logic          rom_cs;
    logic [AW-1:0] rom_addr;
    logic          rom_half;
    logic [DW-1:0] rom_data;
    logic          rom_ok;
    logic          sdram_req;
    logic [SW-1:0] sdram_addr;
    logic          sdram_ack;
    logic          sdram_dok;
    logic [DW-1:0] sdram_data;

    modport slave (
        input  rom_cs, rom_addr, rom_half, sdram_ack, sdram_dok, sdram_data,
        output rom_data, rom_ok, sdram_req, sdram_addr
    );

    modport master (
        output rom_cs, rom_addr, rom_half, sdram_ack, sdram_dok, sdram_data,
        input  rom_data, rom_ok, sdram_req, sdram_addr
    );
endinterface

// File: rtl/jtcps1_gfx_resp.sv
// Two-entry (one per 32-bit half) cache between the CPS1 scroll tile engine
// and its SDRAM slot; misses become single-word requests, with sibling prefetch.
module jtcps1_gfx_resp #(
    parameter logic [21:0] OFFSET   = 22'd0,
    parameter bit          PREFETCH = 1'b1
) (
    input  logic rst,
    input  logic clk,
    input  logic flush,
    jtcps1_gfx_resp_if.slave bus
);
    localparam int unsigned AW = 20;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 22;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [1:0]    valid_q, valid_d;
    logic [AW-1:0] tag_q [2];
    logic [AW-1:0] tag_d [2];
    logic [DW-1:0] data_q [2];
    logic [DW-1:0] data_d [2];
    logic [AW-1:0] req_tag_q, req_tag_d;
    logic          req_half_q, req_half_d;
    logic          sdram_req_q, sdram_req_d;
    logic [SW-1:0] sdram_addr_q, sdram_addr_d;
    logic          pf_pending_q, pf_pending_d;
    logic [AW-1:0] pf_tag_q, pf_tag_d;
    logic          pf_half_q, pf_half_d;
    logic          flushed_q, flushed_d;
    logic          hit, miss;

    function automatic logic [SW-1:0] word_addr(input logic [AW-1:0] tag, input logic half);
        return OFFSET + SW'({tag, half});
    endfunction

    // Lookup is combinational so rom_ok drops the cycle the address leaves a cached word
    assign hit            = valid_q[bus.rom_half] && (tag_q[bus.rom_half] == bus.rom_addr);
    assign miss           = bus.rom_cs && !hit;
    assign bus.rom_ok     = bus.rom_cs && hit;
    assign bus.rom_data   = data_q[bus.rom_half];
    assign bus.sdram_req  = sdram_req_q;
    assign bus.sdram_addr = sdram_addr_q;

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        tag_d        = tag_q;
        data_d       = data_q;
        req_tag_d    = req_tag_q;
        req_half_d   = req_half_q;
        sdram_req_d  = sdram_req_q;
        sdram_addr_d = sdram_addr_q;
        pf_pending_d = pf_pending_q;
        pf_tag_d     = pf_tag_q;
        pf_half_d    = pf_half_q;
        flushed_d    = flushed_q;

        case (state_q)
            ST_IDLE: begin
                flushed_d = 1'b0;
                if (miss) begin
                    req_tag_d    = bus.rom_addr;
                    req_half_d   = bus.rom_half;
                    sdram_req_d  = 1'b1;
                    sdram_addr_d = word_addr(bus.rom_addr, bus.rom_half);
                    state_d      = ST_REQ;
                    // A demand fetch of the pending prefetch target makes it redundant
                    if (pf_tag_q == bus.rom_addr && pf_half_q == bus.rom_half) begin
                        pf_pending_d = 1'b0;
                    end
                end else if (PREFETCH && pf_pending_q && !flush) begin
                    req_tag_d    = pf_tag_q;
                    req_half_d   = pf_half_q;
                    sdram_req_d  = 1'b1;
                    sdram_addr_d = word_addr(pf_tag_q, pf_half_q);
                    pf_pending_d = 1'b0;
                    state_d      = ST_REQ;
                end
            end
            ST_REQ: begin
                if (flush) begin
                    flushed_d = 1'b1;
                end
                if (bus.sdram_ack) begin
                    sdram_req_d = 1'b0;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.sdram_dok) begin
                    state_d   = ST_IDLE;
                    flushed_d = 1'b0;
                    // Data from a transfer overlapped by a flush belongs to the old bank
                    if (!flush && !flushed_q) begin
                        data_d[req_half_q]  = bus.sdram_data;
                        tag_d[req_half_q]   = req_tag_q;
                        valid_d[req_half_q] = 1'b1;
                        if (PREFETCH && !(valid_q[~req_half_q] && tag_q[~req_half_q] == req_tag_q)) begin
                            pf_pending_d = 1'b1;
                            pf_tag_d     = req_tag_q;
                            pf_half_d    = ~req_half_q;
                        end
                    end
                end else if (flush) begin
                    flushed_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush) begin
            valid_d      = 2'b00;
            pf_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            valid_q      <= 2'b00;
            tag_q        <= '{default: '0};
            data_q       <= '{default: '0};
            req_tag_q    <= '0;
            req_half_q   <= 1'b0;
            sdram_req_q  <= 1'b0;
            sdram_addr_q <= '0;
            pf_pending_q <= 1'b0;
            pf_tag_q     <= '0;
            pf_half_q    <= 1'b0;
            flushed_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            data_q       <= data_d;
            req_tag_q    <= req_tag_d;
            req_half_q   <= req_half_d;
            sdram_req_q  <= sdram_req_d;
            sdram_addr_q <= sdram_addr_d;
            pf_pending_q <= pf_pending_d;
            pf_tag_q     <= pf_tag_d;
            pf_half_q    <= pf_half_d;
            flushed_q    <= flushed_d;
        end
    end
endmodule

// File: tb/tb_jtcps1_gfx_resp.sv
// Bench for jtcps1_gfx_resp: lane 0 (OFFSET 0x100000, prefetch) and
// lane 1 (OFFSET 0x3FFFFF, no prefetch), each with its own SDRAM slot model.
`timescale 1ns/1ps
module tb_jtcps1_gfx_resp;
    localparam int NL = 2;
    localparam logic [21:0] OFF0 = 22'h10_0000;
    localparam logic [21:0] OFF1 = 22'h3F_FFFF;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    logic        cs_r       [NL];
    logic [19:0] addr_r     [NL];
    logic        half_r     [NL];
    logic        main_flush [NL];
    int          ack_dly    [NL];
    int          dok_dly    [NL];
    bit          flush_on_dok [NL];

    logic        ok_w    [NL];
    logic [31:0] data_w  [NL];
    logic        req_w   [NL];
    logic [21:0] saddr_w [NL];
    int          rc_w    [NL];
    int          dc_w    [NL];
    logic [21:0] last_w  [NL];
    logic [21:0] prev_w  [NL];

    always #5 clk = ~clk;

    jtcps1_gfx_resp_if ifc [NL] ();

    // SDRAM contents: distinct word per address (odd multiplier is a bijection)
    function automatic logic [31:0] mem_word(input logic [21:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    for (genvar g = 0; g < NL; g++) begin : g_lane
        int          req_cnt;
        int          dok_cnt;
        logic        agent_flush;
        logic [21:0] last_a;
        logic [21:0] prev_a;

        jtcps1_gfx_resp #(.OFFSET(g == 0 ? OFF0 : OFF1), .PREFETCH(g == 0)) u_dut (
            .rst   (rst),
            .clk   (clk),
            .flush (main_flush[g] | agent_flush),
            .bus   (ifc[g].slave)
        );

        assign ifc[g].rom_cs   = cs_r[g];
        assign ifc[g].rom_addr = addr_r[g];
        assign ifc[g].rom_half = half_r[g];
        assign ok_w[g]    = ifc[g].rom_ok;
        assign data_w[g]  = ifc[g].rom_data;
        assign req_w[g]   = ifc[g].sdram_req;
        assign saddr_w[g] = ifc[g].sdram_addr;
        assign rc_w[g]    = req_cnt;
        assign dc_w[g]    = dok_cnt;
        assign last_w[g]  = last_a;
        assign prev_w[g]  = prev_a;

        // Slot model: ack after ack_dly cycles, dok dok_dly cycles after ack
        initial begin
            req_cnt = 0;
            dok_cnt = 0;
            agent_flush = 1'b0;
            last_a = '0;
            prev_a = '0;
            ifc[g].sdram_ack  = 1'b0;
            ifc[g].sdram_dok  = 1'b0;
            ifc[g].sdram_data = '0;
            forever begin
                @(negedge clk);
                if (ifc[g].sdram_req) begin
                    prev_a = last_a;
                    last_a = ifc[g].sdram_addr;
                    req_cnt++;
                    repeat (ack_dly[g]) @(negedge clk);
                    ifc[g].sdram_ack = 1'b1;
                    @(negedge clk);
                    ifc[g].sdram_ack = 1'b0;
                    repeat (dok_dly[g]) @(negedge clk);
                    ifc[g].sdram_data = mem_word(last_a);
                    ifc[g].sdram_dok  = 1'b1;
                    agent_flush = flush_on_dok[g];
                    dok_cnt++;
                    @(negedge clk);
                    ifc[g].sdram_dok = 1'b0;
                    agent_flush = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input int l, input logic cs, input logic [19:0] a, input logic h);
        @(negedge clk);
        cs_r[l] = cs; addr_r[l] = a; half_r[l] = h;
        #1;
    endtask

    task automatic flush_pulse(input int l);
        @(negedge clk);
        main_flush[l] = 1'b1;
        @(negedge clk);
        main_flush[l] = 1'b0;
    endtask

    task automatic wait_ok(input int l, input int budget, output int n);
        n = 0;
        while (!ok_w[l] && n < budget) begin
            tick();
            n++;
        end
        if (!ok_w[l]) begin
            checks++;
            errors++;
            $display("FAIL wait_ok lane %0d: rom_ok low after %0d cycles, required high", l, budget);
        end
    endtask

    typedef struct {
        logic [19:0] addr;
        logic        half;
        logic        exp_hit;
        logic [21:0] exp_saddr;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        tbl [10];
        int          n, r0, d0;
        logic        mv [2];
        logic [19:0] mt [2];
        logic [19:0] a;
        logic        h, exp_hit;
        int          exp_req;

        // Lane 1: OFFSET 0x3FFFFF, no prefetch, 22-bit wrap of the word address
        tbl[0] = '{20'h00001, 1'b0, 1'b0, 22'h00_0001};
        tbl[1] = '{20'h00001, 1'b0, 1'b1, 22'h00_0001};
        tbl[2] = '{20'h00001, 1'b1, 1'b0, 22'h00_0002};
        tbl[3] = '{20'h00001, 1'b0, 1'b1, 22'h00_0001};
        tbl[4] = '{20'hFFFFF, 1'b1, 1'b0, 22'h1F_FFFE};
        tbl[5] = '{20'hFFFFF, 1'b1, 1'b1, 22'h1F_FFFE};
        tbl[6] = '{20'h00001, 1'b1, 1'b0, 22'h00_0002};
        tbl[7] = '{20'h00ABC, 1'b0, 1'b0, 22'h00_1577};
        tbl[8] = '{20'h00001, 1'b1, 1'b1, 22'h00_0002};
        tbl[9] = '{20'h00ABC, 1'b0, 1'b1, 22'h00_1577};

        rst = 1'b1;
        for (int l = 0; l < NL; l++) begin
            cs_r[l] = 1'b0; addr_r[l] = '0; half_r[l] = 1'b0;
            main_flush[l] = 1'b0; ack_dly[l] = 1; dok_dly[l] = 0; flush_on_dok[l] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset then idle
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("reset_ok",   {30'd0, ok_w[1], ok_w[0]}, 32'd0);
            chk("reset_req",  {30'd0, req_w[1], req_w[0]}, 32'd0);
            chk("reset_data", data_w[0] | data_w[1], 32'd0);
        end

        // Cold miss on lane 0 with ack/dok at +1, then sibling prefetch
        r0 = rc_w[0];
        present(0, 1'b1, 20'h00ABC, 1'b1);
        chk("cold_ok_t0", 32'(ok_w[0]), 32'd0);
        wait_ok(0, 20, n);
        chk("cold_latency", n, 4);
        chk("cold_addr", 32'(last_w[0]), 32'h10_1579);
        chk("cold_data", data_w[0], mem_word(22'h10_1579));
        tick();
        chk("pf_req", 32'(req_w[0]), 32'd1);
        chk("pf_addr", 32'(saddr_w[0]), 32'h10_1578);
        chk("pf_keep_ok", 32'(ok_w[0]), 32'd1);
        repeat (8) tick();
        present(0, 1'b1, 20'h00ABC, 1'b0);
        chk("pf_sibling_ok", 32'(ok_w[0]), 32'd1);
        chk("pf_sibling_data", data_w[0], mem_word(22'h10_1578));
        for (int t = 0; t < 6; t++) begin
            present(0, 1'b1, 20'h00ABC, 1'(t % 2));
            chk("pf_toggle_ok", 32'(ok_w[0]), 32'd1);
        end
        chk("pf_req_count", rc_w[0] - r0, 2);
        present(0, 1'b1, 20'h00ABD, 1'b0);
        chk("ok_falls", 32'(ok_w[0]), 32'd0);
        wait_ok(0, 20, n);
        present(0, 1'b0, 20'h00ABD, 1'b0);
        repeat (16) tick();

        // Address change before ack: first transfer completes, then the new address
        ack_dly[0] = 2; dok_dly[0] = 1;
        r0 = rc_w[0]; d0 = dc_w[0];
        present(0, 1'b1, 20'h00001, 1'b0);
        tick(); tick();
        present(0, 1'b1, 20'h00002, 1'b0);
        chk("chg_ok_low", 32'(ok_w[0]), 32'd0);
        wait_ok(0, 40, n);
        chk("chg_req_count", rc_w[0] - r0, 2);
        chk("chg_dok_count", dc_w[0] - d0, 2);
        chk("chg_first_addr", 32'(prev_w[0]), 32'h10_0002);
        chk("chg_second_addr", 32'(last_w[0]), 32'h10_0004);
        chk("chg_data", data_w[0], mem_word(22'h10_0004));
        present(0, 1'b0, 20'h00002, 1'b0);
        repeat (16) tick();

        // Flush in the same cycle as dok: data dropped, same address re-requested
        ack_dly[0] = 0; dok_dly[0] = 2; flush_on_dok[0] = 1'b1;
        d0 = dc_w[0];
        present(0, 1'b1, 20'h00005, 1'b1);
        n = 0;
        while (dc_w[0] == d0 && n < 20) begin
            tick();
            n++;
        end
        flush_on_dok[0] = 1'b0;
        chk("flush_dok_seen", 32'(dc_w[0] - d0), 32'd1);
        chk("flush_dok_ok", 32'(ok_w[0]), 32'd0);
        tick();
        chk("flush_rereq", 32'(req_w[0]), 32'd1);
        chk("flush_rereq_addr", 32'(saddr_w[0]), 32'h10_000B);
        chk("flush_ok_still_low", 32'(ok_w[0]), 32'd0);
        wait_ok(0, 20, n);
        chk("flush_refill_data", data_w[0], mem_word(22'h10_000B));
        present(0, 1'b0, 20'h00005, 1'b1);
        repeat (16) tick();

        // Table vectors on lane 1
        ack_dly[1] = 1; dok_dly[1] = 1;
        for (int i = 0; i < 10; i++) begin
            r0 = rc_w[1];
            present(1, 1'b1, tbl[i].addr, tbl[i].half);
            chk("tbl_hit_t0", 32'(ok_w[1]), 32'(tbl[i].exp_hit));
            wait_ok(1, 30, n);
            chk("tbl_data", data_w[1], mem_word(tbl[i].exp_saddr));
            present(1, 1'b0, tbl[i].addr, tbl[i].half);
            repeat (8) tick();
            chk("tbl_reqs", rc_w[1] - r0, tbl[i].exp_hit ? 0 : 1);
            if (!tbl[i].exp_hit) chk("tbl_saddr", 32'(last_w[1]), 32'(tbl[i].exp_saddr));
        end

        // Randomized accesses on lane 0 against a settled-state cache model
        flush_pulse(0);
        mv[0] = 1'b0; mv[1] = 1'b0; mt[0] = '0; mt[1] = '0;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(9) == 0) begin
                flush_pulse(0);
                mv[0] = 1'b0; mv[1] = 1'b0;
                continue;
            end
            a = 20'h00010 + 20'($urandom_range(2));
            h = 1'($urandom_range(1));
            ack_dly[0] = $urandom_range(3);
            dok_dly[0] = $urandom_range(3);
            exp_hit = mv[h] && mt[h] == a;
            exp_req = exp_hit ? 0 : ((mv[!h] && mt[!h] == a) ? 1 : 2);
            r0 = rc_w[0];
            present(0, 1'b1, a, h);
            chk("rnd_hit", 32'(ok_w[0]), 32'(exp_hit));
            wait_ok(0, 40, n);
            chk("rnd_data", data_w[0], mem_word(OFF0 + 22'({a, h})));
            present(0, 1'b0, a, h);
            repeat (20) tick();
            chk("rnd_reqs", rc_w[0] - r0, exp_req);
            if (!exp_hit) begin
                mv[0] = 1'b1; mv[1] = 1'b1; mt[0] = a; mt[1] = a;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
